// File: rtl/rob_multiport.sv
// N-wide reorder buffer: in-order multi-lane allocate/retire, one completion port,
// source-operand lookup with same-cycle completion bypass, and full flush.

module rob_src_port #(
  parameter int DEPTH = 16,
  parameter int RES_W = 70,
  parameter int TAG_W = 5
) (
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0]            done_i,
  input  logic [DEPTH-1:0][RES_W-1:0] res_i,
  input  logic                        cmpl_valid_i,
  input  logic [TAG_W-1:0]            cmpl_tag_i,
  input  logic [RES_W-1:0]            cmpl_data_i,
  output logic                        done_o,
  output logic [RES_W-1:0]            data_o
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [IDX_W-1:0] idx;
  logic             hit, byp, stored;

  assign idx    = IDX_W'(tag_i - TAG_W'(1));
  // Tags above DEPTH can never be allocated; treat them like tag 0
  assign hit    = (tag_i != '0) && (tag_i <= TAG_W'(DEPTH)) && valid_i[idx];
  assign byp    = hit && cmpl_valid_i && (cmpl_tag_i == tag_i);
  assign stored = hit && done_i[idx];
  assign done_o = byp || stored;
  assign data_o = byp ? cmpl_data_i : (stored ? res_i[idx] : '0);
endmodule

module rob_multiport #(
  parameter int DEPTH     = 16,
  parameter int LANES     = 2,
  parameter int DISP_W    = 9,
  parameter int RES_W     = 70,
  parameter int SRC_PORTS = 4,
  parameter int TAG_W     = $clog2(DEPTH) + 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic [LANES-1:0]                 disp_valid_i,
  input  logic [LANES*DISP_W-1:0]          disp_data_i,
  output logic                             disp_ready_o,
  output logic [LANES*TAG_W-1:0]           disp_tag_o,
  input  logic                             cmpl_valid_i,
  input  logic [TAG_W-1:0]                 cmpl_tag_i,
  input  logic [RES_W-1:0]                 cmpl_data_i,
  input  logic [SRC_PORTS*TAG_W-1:0]       src_tag_i,
  output logic [SRC_PORTS-1:0]             src_done_o,
  output logic [SRC_PORTS*RES_W-1:0]       src_data_o,
  output logic [LANES-1:0]                 cmt_valid_o,
  input  logic [LANES-1:0]                 cmt_ready_i,
  output logic [LANES*TAG_W-1:0]           cmt_tag_o,
  output logic [LANES*(DISP_W+RES_W)-1:0]  cmt_data_o,
  output logic [$clog2(DEPTH):0]           count_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0]              valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0][DISP_W-1:0]  disp_q, disp_d;
  logic [DEPTH-1:0][RES_W-1:0]   res_q, res_d;

  logic [LANES-1:0][IDX_W-1:0]   d_idx, c_idx;
  logic [LANES-1:0]              cmt_vld;
  logic [CNT_W-1:0]              n_disp, n_ret;
  logic                          disp_acc, run_d, run_c, all_done;
  logic [IDX_W-1:0]              cidx;
  logic                          cmpl_hit;

  assign disp_ready_o = (count_q <= CNT_W'(DEPTH - LANES));
  assign disp_acc     = disp_ready_o && disp_valid_i[0];
  assign cidx         = IDX_W'(cmpl_tag_i - TAG_W'(1));
  assign cmpl_hit     = cmpl_valid_i && (cmpl_tag_i != '0) &&
                        (cmpl_tag_i <= TAG_W'(DEPTH)) && valid_q[cidx];
  assign count_o      = count_q;
  assign cmt_valid_o  = cmt_vld;

  // Lane slots, leading-run dispatch count and prefix-rule retire count
  always_comb begin
    n_disp   = '0;
    n_ret    = '0;
    run_d    = disp_acc;
    run_c    = 1'b1;
    all_done = 1'b1;
    d_idx    = '0;
    c_idx    = '0;
    cmt_vld  = '0;
    for (int k = 0; k < LANES; k++) begin
      d_idx[k]   = tail_q + IDX_W'(k);
      c_idx[k]   = head_q + IDX_W'(k);
      all_done   = all_done && valid_q[c_idx[k]] && done_q[c_idx[k]];
      cmt_vld[k] = all_done;
      if (run_d && disp_valid_i[k]) n_disp = n_disp + CNT_W'(1);
      else                          run_d  = 1'b0;
      if (run_c && cmt_vld[k] && cmt_ready_i[k]) n_ret = n_ret + CNT_W'(1);
      else                                       run_c = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    disp_d  = disp_q;
    res_d   = res_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (cmpl_hit) begin
        res_d[cidx]  = cmpl_data_i;
        done_d[cidx] = 1'b1;
      end
      for (int k = 0; k < LANES; k++) begin
        if (CNT_W'(k) < n_ret) begin
          valid_d[c_idx[k]] = 1'b0;
          done_d[c_idx[k]]  = 1'b0;
        end
      end
      // Dispatch only ever targets free slots, so it cannot collide with retire
      for (int k = 0; k < LANES; k++) begin
        if (CNT_W'(k) < n_disp) begin
          valid_d[d_idx[k]] = 1'b1;
          done_d[d_idx[k]]  = 1'b0;
          disp_d[d_idx[k]]  = disp_data_i[k*DISP_W +: DISP_W];
        end
      end
      head_d  = head_q + n_ret[IDX_W-1:0];
      tail_d  = tail_q + n_disp[IDX_W-1:0];
      count_d = count_q + n_disp - n_ret;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      disp_q  <= '0;
      res_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      res_q   <= res_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign disp_tag_o[k*TAG_W +: TAG_W] = TAG_W'(d_idx[k]) + TAG_W'(1);
    assign cmt_tag_o[k*TAG_W +: TAG_W]  = TAG_W'(c_idx[k]) + TAG_W'(1);
    assign cmt_data_o[k*(DISP_W+RES_W) +: (DISP_W+RES_W)] = {disp_q[c_idx[k]], res_q[c_idx[k]]};
  end

  for (genvar p = 0; p < SRC_PORTS; p++) begin : g_src
    rob_src_port #(.DEPTH(DEPTH), .RES_W(RES_W), .TAG_W(TAG_W)) u_src (
      .tag_i        (src_tag_i[p*TAG_W +: TAG_W]),
      .valid_i      (valid_q),
      .done_i       (done_q),
      .res_i        (res_q),
      .cmpl_valid_i (cmpl_valid_i),
      .cmpl_tag_i   (cmpl_tag_i),
      .cmpl_data_i  (cmpl_data_i),
      .done_o       (src_done_o[p]),
      .data_o       (src_data_o[p*RES_W +: RES_W])
    );
  end
endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based model of the buffer.

module tb_rob_multiport;
  localparam int DEPTH = 16, LANES = 2, DISP_W = 9, RES_W = 70, SRC_PORTS = 4;
  localparam int TAG_W = 5, CNT_W = 5;

  logic clk = 0, reset_i = 1, flush;
  logic [LANES-1:0] dv, cr;
  logic [LANES*DISP_W-1:0] ddata;
  logic cvld;
  logic [TAG_W-1:0] ctag;
  logic [RES_W-1:0] cdata;
  logic [SRC_PORTS*TAG_W-1:0] stag;
  logic disp_ready_o;
  logic [LANES*TAG_W-1:0] disp_tag_o, cmt_tag_o;
  logic [SRC_PORTS-1:0] src_done_o;
  logic [SRC_PORTS*RES_W-1:0] src_data_o;
  logic [LANES-1:0] cmt_valid_o;
  logic [LANES*(DISP_W+RES_W)-1:0] cmt_data_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk = ~clk;

  rob_multiport dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush),
    .disp_valid_i(dv), .disp_data_i(ddata), .disp_ready_o(disp_ready_o), .disp_tag_o(disp_tag_o),
    .cmpl_valid_i(cvld), .cmpl_tag_i(ctag), .cmpl_data_i(cdata),
    .src_tag_i(stag), .src_done_o(src_done_o), .src_data_o(src_data_o),
    .cmt_valid_o(cmt_valid_o), .cmt_ready_i(cr), .cmt_tag_o(cmt_tag_o), .cmt_data_o(cmt_data_o),
    .count_o(count_o)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: program-order queue of live entries plus the next free slot
  typedef struct {
    int               tag;
    logic [DISP_W-1:0] d;
    bit               done;
    logic [RES_W-1:0] r;
  } ent_t;
  ent_t mq[$];
  int m_tail = 0;

  function automatic bit m_ready();
    return mq.size() <= DEPTH - LANES;
  endfunction

  function automatic int m_tag(int k);
    return ((m_tail + k) % DEPTH) + 1;
  endfunction

  function automatic int find(int t);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  function automatic logic [LANES-1:0] m_cv();
    logic [LANES-1:0] v = '0;
    bit ok = 1;
    for (int k = 0; k < LANES; k++) begin
      if (k < mq.size()) ok = ok && mq[k].done;
      else               ok = 0;
      v[k] = ok;
    end
    return v;
  endfunction

  task automatic mcheck();
    logic [LANES-1:0] cv;
    chk("ready", disp_ready_o, m_ready());
    chk("count", count_o, mq.size());
    for (int k = 0; k < LANES; k++) chk("disp_tag", disp_tag_o[k*TAG_W +: TAG_W], m_tag(k));
    cv = m_cv();
    chk("cmt_valid", cmt_valid_o, cv);
    for (int k = 0; k < LANES; k++) begin
      if (cv[k]) begin
        chk("cmt_tag", cmt_tag_o[k*TAG_W +: TAG_W], mq[k].tag);
        chk("cmt_data", cmt_data_o[k*(DISP_W+RES_W) +: (DISP_W+RES_W)], {mq[k].d, mq[k].r});
      end
    end
    for (int p = 0; p < SRC_PORTS; p++) begin
      int t = int'(stag[p*TAG_W +: TAG_W]);
      int i = find(t);
      logic ed = 0;
      logic [RES_W-1:0] edat = '0;
      if (i >= 0) begin
        if (cvld && int'(ctag) == t) begin ed = 1; edat = cdata; end
        else if (mq[i].done)          begin ed = 1; edat = mq[i].r; end
      end
      chk("src_done", src_done_o[p], ed);
      chk("src_data", src_data_o[p*RES_W +: RES_W], edat);
    end
  endtask

  task automatic m_update();
    int nd = 0, r = 0, i;
    bit run = 1;
    logic [LANES-1:0] cv;
    if (flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    if (m_ready() && dv[0])
      for (int k = 0; k < LANES; k++) begin
        if (run && dv[k]) nd++; else run = 0;
      end
    cv = m_cv();
    run = 1;
    for (int k = 0; k < LANES; k++) begin
      if (run && cv[k] && cr[k]) r++; else run = 0;
    end
    if (cvld) begin
      i = find(int'(ctag));
      if (i >= 0) begin mq[i].done = 1; mq[i].r = cdata; end
    end
    repeat (r) void'(mq.pop_front());
    for (int k = 0; k < nd; k++) begin
      ent_t e;
      e.tag = m_tag(k); e.d = ddata[k*DISP_W +: DISP_W]; e.done = 0; e.r = '0;
      mq.push_back(e);
    end
    m_tail = (m_tail + nd) % DEPTH;
  endtask

  task automatic idle();
    flush = 0; dv = '0; ddata = '0; cvld = 0; ctag = '0; cdata = '0; stag = '0; cr = '0;
  endtask

  task automatic apply();
    @(negedge clk); #1;
    mcheck();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_update();
  endtask

  typedef struct {
    logic fl; logic [1:0] dv; logic cv; logic [4:0] ct; logic [RES_W-1:0] cd;
    logic [4:0] st; logic [1:0] cr;
    logic [4:0] e_cnt; logic e_rdy; logic [4:0] e_t0, e_t1; logic [1:0] e_cv;
    logic [4:0] e_ct0; logic e_sd; logic [RES_W-1:0] e_sdat;
  } vec_t;

  function automatic vec_t mk(logic fl, logic [1:0] v, logic c, logic [4:0] ct, logic [RES_W-1:0] cd,
                              logic [4:0] st, logic [1:0] r, logic [4:0] n, logic rd, logic [4:0] t0,
                              logic [4:0] t1, logic [1:0] ecv, logic [4:0] ect, logic sd,
                              logic [RES_W-1:0] sdat);
    vec_t x;
    x.fl = fl; x.dv = v; x.cv = c; x.ct = ct; x.cd = cd; x.st = st; x.cr = r;
    x.e_cnt = n; x.e_rdy = rd; x.e_t0 = t0; x.e_t1 = t1; x.e_cv = ecv; x.e_ct0 = ect;
    x.e_sd = sd; x.e_sdat = sdat;
    return x;
  endfunction

  function automatic logic [4:0] pick_tag();
    if (mq.size() > 0 && $urandom_range(0, 4) != 0)
      return 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
    return 5'($urandom_range(0, 31));
  endfunction

  vec_t tbl[11];

  initial begin
    idle();
    tbl[0]  = mk(0, 2'b11, 0, 0, 0,     0, 2'b00, 0, 1, 1, 2, 2'b00, 0, 0, 0);
    tbl[1]  = mk(0, 2'b11, 1, 2, 'h22,  2, 2'b00, 2, 1, 3, 4, 2'b00, 0, 1, 'h22);
    tbl[2]  = mk(0, 2'b00, 1, 1, 'h21,  2, 2'b11, 4, 1, 5, 6, 2'b00, 0, 1, 'h22);
    tbl[3]  = mk(0, 2'b00, 0, 0, 0,     1, 2'b10, 4, 1, 5, 6, 2'b11, 1, 1, 'h21);
    tbl[4]  = mk(0, 2'b00, 0, 0, 0,     1, 2'b11, 4, 1, 5, 6, 2'b11, 1, 1, 'h21);
    tbl[5]  = mk(0, 2'b01, 1, 0, 'hff,  0, 2'b11, 2, 1, 5, 6, 2'b00, 0, 0, 0);
    tbl[6]  = mk(0, 2'b00, 1, 5, 'h2a,  5, 2'b00, 3, 1, 6, 7, 2'b00, 0, 1, 'h2a);
    tbl[7]  = mk(0, 2'b00, 1, 3, 'h33,  5, 2'b11, 3, 1, 6, 7, 2'b00, 0, 1, 'h2a);
    tbl[8]  = mk(0, 2'b00, 0, 0, 0,     4, 2'b01, 3, 1, 6, 7, 2'b01, 3, 0, 0);
    tbl[9]  = mk(1, 2'b11, 1, 4, 'h44,  4, 2'b11, 2, 1, 6, 7, 2'b00, 0, 1, 'h44);
    tbl[10] = mk(0, 2'b00, 0, 0, 0,     4, 2'b00, 0, 1, 1, 2, 2'b00, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2 reset_i = 0;
    mq.delete(); m_tail = 0;

    for (int i = 0; i < 11; i++) begin
      flush = tbl[i].fl; dv = tbl[i].dv; cvld = tbl[i].cv; ctag = tbl[i].ct; cdata = tbl[i].cd;
      stag = {15'd0, tbl[i].st}; cr = tbl[i].cr; ddata = 18'($urandom);
      apply();
      chk($sformatf("t%0d_count", i), count_o, tbl[i].e_cnt);
      chk($sformatf("t%0d_ready", i), disp_ready_o, tbl[i].e_rdy);
      chk($sformatf("t%0d_tag0", i), disp_tag_o[4:0], tbl[i].e_t0);
      chk($sformatf("t%0d_tag1", i), disp_tag_o[9:5], tbl[i].e_t1);
      chk($sformatf("t%0d_cmt_valid", i), cmt_valid_o, tbl[i].e_cv);
      if (tbl[i].e_cv[0]) chk($sformatf("t%0d_cmt_tag0", i), cmt_tag_o[4:0], tbl[i].e_ct0);
      chk($sformatf("t%0d_src_done", i), src_done_o[0], tbl[i].e_sd);
      chk($sformatf("t%0d_src_data", i), src_data_o[RES_W-1:0], tbl[i].e_sdat);
      tick();
    end

    // Wrap and full: move head/tail to slot 1, fill to 14, then dispatch across slot 15
    idle(); dv = 2'b01; apply(); tick();
    idle(); cvld = 1; ctag = 1; cdata = 'h1; apply(); tick();
    idle(); cr = 2'b11; apply(); chk("wrap_cmt_valid", cmt_valid_o, 2'b01); tick();
    for (int i = 0; i < 7; i++) begin
      idle(); dv = 2'b11; ddata = 18'($urandom); apply(); tick();
    end
    idle(); dv = 2'b11; apply();
    chk("wrap_count14", count_o, 14);
    chk("wrap_tag0", disp_tag_o[4:0], 16);
    chk("wrap_tag1", disp_tag_o[9:5], 1);
    tick();
    idle(); dv = 2'b11; apply();
    chk("full_count", count_o, 16);
    chk("full_ready", disp_ready_o, 0);
    tick();
    idle(); apply(); chk("full_hold", count_o, 16); tick();
    idle(); cvld = 1; ctag = 2; cdata = 'h55; apply(); tick();
    idle(); cr = 2'b01; apply(); chk("one_cmt_valid", cmt_valid_o, 2'b01); tick();
    idle(); dv = 2'b11; apply();
    chk("c15_count", count_o, 15);
    chk("c15_ready", disp_ready_o, 0);
    tick();
    idle(); apply(); chk("c15_hold", count_o, 15); tick();

    // Flush beats same-cycle dispatch, completion and commit
    idle(); flush = 1; dv = 2'b11; cvld = 1; ctag = 3; cr = 2'b11; apply(); tick();
    idle(); apply();
    chk("flush_count", count_o, 0);
    chk("flush_cmt_valid", cmt_valid_o, 0);
    tick();

    // Asynchronous reset between clock edges
    idle(); dv = 2'b11; apply(); tick();
    chk("pre_rst_count", count_o, 2);
    idle();
    #2 reset_i = 1;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_tag0", disp_tag_o[4:0], 1);
    chk("arst_cmt_valid", cmt_valid_o, 0);
    mq.delete(); m_tail = 0;
    @(negedge clk); reset_i = 0;

    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      flush = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 7);
      dv = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10;
      ddata = 18'($urandom);
      cvld = $urandom_range(0, 1);
      ctag = pick_tag();
      cdata = {6'($urandom), $urandom, $urandom};
      for (int p = 0; p < SRC_PORTS; p++) stag[p*TAG_W +: TAG_W] = pick_tag();
      cr = 2'($urandom);
      apply();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
